hsv_core_commit: RTL



---
 rtl/hsv_core_pkg.sv | 21 ++
 rtl/hsv_core_commit_flush_tracker.sv | 37 +++
 rtl/hsv_core_commit.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/hsv_core_pkg.sv
// Shared types for the hsv core commit slice: the retiring-instruction
// record and the commit stage state encoding.
package hsv_core_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] rd_value;
    logic        writeback;
    logic        jump;
    logic [31:0] jump_target;
    logic        trap;
  } commit_data_t;

  typedef enum logic [1:0] {
    COMMIT_RUN,
    COMMIT_FLUSH,
    COMMIT_REDIRECT
  } commit_state_t;

endpackage

// File: rtl/hsv_core_commit_flush_tracker.sv
// Collects per-unit flush acknowledges into a sticky register. all_acked_o
// looks through to the live acks so a unit acking in the same cycle counts.
module hsv_core_commit_flush_tracker #(
  parameter int unsigned NUM_UNITS = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 collect_i,
  input  logic [NUM_UNITS-1:0] flush_ack_i,
  output logic                 all_acked_o
);

  logic [NUM_UNITS-1:0] sticky_q, sticky_d;

  // Clear on a new flush, otherwise accumulate acks only while collecting.
  always_comb begin
    sticky_d = sticky_q;
    if (clear_i) begin
      sticky_d = '0;
    end else if (collect_i) begin
      sticky_d = sticky_q | flush_ack_i;
    end
  end

  // Sticky ack register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign all_acked_o = &(sticky_q | flush_ack_i);

endmodule

// File: rtl/hsv_core_commit.sv
// In-order commit stage: retires one entry per cycle onto the register-file
// write port and, on a taken jump or trap, runs the flush_req/flush_ack
// handshake before emitting a single-cycle redirect to fetch.
// Optional: define HSV_COMMIT_MINSTRET_EN to add the 64-bit minstret counter.
//
// state           | meaning
// COMMIT_RUN      | accepting entries
// COMMIT_FLUSH    | flush_req high, waiting for every unit to ack
// COMMIT_REDIRECT | redirect_valid pulse to fetch
module hsv_core_commit
  import hsv_core_pkg::*;
#(
  parameter int unsigned NUM_UNITS   = 1,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic                 clk_core,
  input  logic                 rst_core,
  input  commit_data_t         commit_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [NUM_UNITS-1:0] flush_req,
  input  logic [NUM_UNITS-1:0] flush_ack,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [31:0]          rf_wdata,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc
`ifdef HSV_COMMIT_MINSTRET_EN
  ,
  output logic [63:0]          minstret
`endif
);

  commit_state_t        state_q, state_d;
  logic [NUM_UNITS-1:0] flush_req_q, flush_req_d;
  logic                 rf_we_q, rf_we_d;
  logic [4:0]           rf_waddr_q, rf_waddr_d;
  logic [31:0]          rf_wdata_q, rf_wdata_d;
  logic                 redirect_valid_q, redirect_valid_d;
  logic [31:0]          redirect_pc_q, redirect_pc_d;
  logic [31:0]          target_q, target_d;
  logic                 accept;
  logic                 clear_acks;
  logic                 all_acked;
  logic                 pc_unused;

  // The retiring PC is carried in the record but not needed here.
  assign pc_unused = ^commit_data.pc;

  assign in_ready = (state_q == COMMIT_RUN);
  assign accept   = in_valid & in_ready;

  hsv_core_commit_flush_tracker #(
    .NUM_UNITS (NUM_UNITS)
  ) u_flush_tracker (
    .clk_i       (clk_core),
    .rst_i       (rst_core),
    .clear_i     (clear_acks),
    .collect_i   (state_q == COMMIT_FLUSH),
    .flush_ack_i (flush_ack),
    .all_acked_o (all_acked)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d          = state_q;
    flush_req_d      = flush_req_q;
    rf_we_d          = 1'b0;
    rf_waddr_d       = rf_waddr_q;
    rf_wdata_d       = rf_wdata_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    target_d         = target_q;
    clear_acks       = 1'b0;
    unique case (state_q)
      COMMIT_RUN: begin
        if (accept) begin
          // Traps never write back; x0 writes (jump links too) are dropped.
          rf_we_d    = commit_data.writeback & ~commit_data.trap &
                       (commit_data.rd != 5'd0);
          rf_waddr_d = commit_data.rd;
          rf_wdata_d = commit_data.rd_value;
          if (commit_data.jump | commit_data.trap) begin
            state_d     = COMMIT_FLUSH;
            flush_req_d = '1;
            clear_acks  = 1'b1;
            target_d    = commit_data.trap ? TRAP_VECTOR : commit_data.jump_target;
          end
        end
      end
      COMMIT_FLUSH: begin
        if (all_acked) begin
          state_d          = COMMIT_REDIRECT;
          flush_req_d      = '0;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = target_q;
        end
      end
      COMMIT_REDIRECT: begin
        state_d = COMMIT_RUN;
      end
      default: begin
        state_d = COMMIT_RUN;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      state_q          <= COMMIT_RUN;
      flush_req_q      <= '0;
      rf_we_q          <= 1'b0;
      rf_waddr_q       <= 5'd0;
      rf_wdata_q       <= 32'd0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
      target_q         <= 32'd0;
    end else begin
      state_q          <= state_d;
      flush_req_q      <= flush_req_d;
      rf_we_q          <= rf_we_d;
      rf_waddr_q       <= rf_waddr_d;
      rf_wdata_q       <= rf_wdata_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      target_q         <= target_d;
    end
  end

  assign flush_req      = flush_req_q;
  assign rf_we          = rf_we_q;
  assign rf_waddr       = rf_waddr_q;
  assign rf_wdata       = rf_wdata_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

`ifdef HSV_COMMIT_MINSTRET_EN
  logic [63:0] minstret_q, minstret_d;

  // Count retired non-trapping entries; wraps naturally at 2^64.
  always_comb begin
    minstret_d = minstret_q;
    if (accept && !commit_data.trap) begin
      minstret_d = minstret_q + 64'd1;
    end
  end

  // Retired-instruction counter register.
  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      minstret_q <= 64'd0;
    end else begin
      minstret_q <= minstret_d;
    end
  end

  assign minstret = minstret_q;
`endif

endmodule
